// File: rtl/timer_pkg.sv
// Shared types and constants for the multi-channel timer.
package timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chan_state_t;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN FSM with a WIDTH-bit down-counter and a
// registered one-cycle terminal-count strobe. busy mirrors the FSM state.
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  output logic             tc,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  chan_state_t      state_q, state_d;
  logic [WIDTH-1:0] ctr_q, ctr_d;
  logic             tc_q, tc_d;

  // Priority inside RUN: start reload, then stop, then expiry, then decrement.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    tc_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          ctr_d   = period;
        end
      end
      RUN: begin
        if (start) begin
          ctr_d = period;
        end else if (stop) begin
          state_d = IDLE;
        end else if (tick && en) begin
          if (ctr_q == '0) begin
            tc_d = 1'b1;
            if (mode == MODE_ONESHOT) begin
              state_d = IDLE;
            end else begin
              ctr_d = period;
            end
          end else begin
            ctr_d = ctr_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      tc_q    <= tc_d;
    end
  end

  assign tc    = tc_q;
  assign busy  = (state_q == RUN);
  assign count = ctr_q;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel programmable timer: a shared prescaler produces a registered
// tick enable that drives NUM_CH independent down-counting channels.
module multi_timer
  import timer_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = 16,
  parameter int PRE_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PRE_WIDTH-1:0]    prescale,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH*WIDTH-1:0] period,
  output logic [NUM_CH-1:0]       tc,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH*WIDTH-1:0] count
);

  logic [PRE_WIDTH-1:0] pre_ctr_q, pre_ctr_d;
  logic                 tick_q, tick_d;
  logic                 pre_hit;

  // ">=" rather than "==" so lowering prescale mid-count wraps right away.
  assign pre_hit = (pre_ctr_q >= prescale);

  always_comb begin
    tick_d    = pre_hit;
    pre_ctr_d = pre_hit ? '0 : pre_ctr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_ctr_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      pre_ctr_q <= pre_ctr_d;
      tick_q    <= tick_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick_q),
      .en    (en[i]),
      .start (start[i]),
      .stop  (stop[i]),
      .mode  (mode[i]),
      .period(period[i*WIDTH +: WIDTH]),
      .tc    (tc[i]),
      .busy  (busy[i]),
      .count (count[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer: expected tc pulses (cycle, channel) are queued by the
// stimulus and consumed by a monitor that watches tc on every falling edge.
module tb_multi_timer;

  localparam int NUM_CH    = 4;
  localparam int WIDTH     = 16;
  localparam int PRE_WIDTH = 8;

  logic                    clk;
  logic                    rst;
  logic [PRE_WIDTH-1:0]    prescale;
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       stop;
  logic [NUM_CH-1:0]       mode;
  logic [NUM_CH*WIDTH-1:0] period;
  logic [NUM_CH-1:0]       tc;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH*WIDTH-1:0] count;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [31:0] exp_q[$];

  multi_timer #(
    .NUM_CH(NUM_CH), .WIDTH(WIDTH), .PRE_WIDTH(PRE_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .prescale(prescale), .en(en), .start(start),
    .stop(stop), .mode(mode), .period(period), .tc(tc), .busy(busy),
    .count(count)
  );

  // Clock / reset / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic do_reset(output int r);
    rst = 1'b1;
    start = '0;
    stop = '0;
    en = '1;
    step();
    step();
    rst = 1'b0;
    r = cyc;
  endtask

  task automatic pulse_start(input logic [NUM_CH-1:0] m);
    start = m;
    step();
    start = '0;
  endtask

  task automatic pulse_stop(input logic [NUM_CH-1:0] m);
    stop = m;
    step();
    stop = '0;
  endtask

  task automatic set_period(input int ch, input int val);
    period[ch*WIDTH +: WIDTH] = WIDTH'(val);
  endtask

  task automatic push_tc(input int c, input int ch);
    exp_q.push_back((32'(c) << 5) | 32'(ch));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt(input int ch);
    return 32'(count[ch*WIDTH +: WIDTH]);
  endfunction

  // Scoreboard monitor: every observed tc pulse must match the queue head
  always @(negedge clk) begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (tc[ch] === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL tc_unexpected: ch=%0d cyc=%0d got=pulse expected=none", ch, cyc);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (e !== ((32'(cyc) << 5) | 32'(ch))) begin
            fails++;
            $display("FAIL tc_match: got ch=%0d cyc=%0d expected ch=%0d cyc=%0d",
                     ch, cyc, e[4:0], e[31:5]);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    int r;
    int l;
    rst = 1'b1;
    prescale = '0;
    en = '1;
    start = '0;
    stop = '0;
    mode = '0;
    period = '0;

    // Reset state
    do_reset(r);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_tc", 32'(tc), 32'd0);
    check("reset_count0", cnt(0), 32'd0);

    // T1: prescale 0, ch0 periodic period 3 -> tc every 4 cycles
    set_period(0, 3);
    step();
    step();
    pulse_start(4'b0001);
    l = cyc;
    for (int k = 1; k <= 3; k++) push_tc(l + 4 * k, 0);
    check("t1_busy", 32'(busy[0]), 32'd1);
    check("t1_cnt_a", cnt(0), 32'd3);
    step();
    check("t1_cnt_b", cnt(0), 32'd2);
    step();
    check("t1_cnt_c", cnt(0), 32'd1);
    step();
    check("t1_cnt_d", cnt(0), 32'd0);
    step();
    check("t1_cnt_e", cnt(0), 32'd3);
    step_to(l + 12);
    pulse_stop(4'b0001);
    check("t1_stop_busy", 32'(busy[0]), 32'd0);
    check("t1_stop_cnt", cnt(0), 32'd3);
    repeat (10) step();
    check("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // T2: prescale 4, ch1 one-shot period 2 -> single tc 15 cycles after load
    prescale = 8'd4;
    mode = 4'b0010;
    set_period(1, 2);
    do_reset(r);
    pulse_start(4'b0010);
    l = cyc;
    push_tc(l + 15, 1);
    check("t2_busy_on", 32'(busy[1]), 32'd1);
    step_to(l + 14);
    check("t2_busy_before", 32'(busy[1]), 32'd1);
    step();
    check("t2_busy_off", 32'(busy[1]), 32'd0);
    check("t2_cnt", cnt(1), 32'd0);
    repeat (100) step();
    check("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // T3: ch0 period 5, en low for 10 cycles -> interval stretched by 10
    prescale = '0;
    mode = '0;
    set_period(0, 5);
    do_reset(r);
    step();
    step();
    pulse_start(4'b0001);
    l = cyc;
    push_tc(l + 16, 0);
    push_tc(l + 22, 0);
    step_to(l + 2);
    check("t3_cnt_pre", cnt(0), 32'd3);
    en[0] = 1'b0;
    step_to(l + 12);
    check("t3_cnt_hold", cnt(0), 32'd3);
    check("t3_busy_hold", 32'(busy[0]), 32'd1);
    en[0] = 1'b1;
    step_to(l + 23);
    pulse_stop(4'b0001);
    check("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // T4: start on ch2 coincides with expiry; period change waits for reload
    set_period(2, 7);
    do_reset(r);
    step();
    step();
    pulse_start(4'b0100);
    l = cyc;
    step_to(l + 7);
    check("t4_cnt_zero", cnt(2), 32'd0);
    pulse_start(4'b0100);
    l = cyc;
    check("t4_no_tc", 32'(tc[2]), 32'd0);
    check("t4_reload", cnt(2), 32'd7);
    push_tc(l + 8, 2);
    push_tc(l + 11, 2);
    push_tc(l + 14, 2);
    step();
    set_period(2, 2);
    step();
    check("t4_cnt_mid", cnt(2), 32'd5);
    step_to(l + 8);
    check("t4_new_period", cnt(2), 32'd2);
    step_to(l + 15);
    pulse_stop(4'b0100);
    check("t4_q_empty", 32'(exp_q.size()), 32'd0);

    // T5: periods 0..3 on all channels together; T6: reset mid-run
    for (int ch = 0; ch < NUM_CH; ch++) set_period(ch, ch);
    do_reset(r);
    step();
    step();
    pulse_start(4'b1111);
    l = cyc;
    for (int c = 1; c <= 12; c++)
      for (int ch = 0; ch < NUM_CH; ch++)
        if (c % (ch + 1) == 0) push_tc(l + c, ch);
    step_to(l + 12);
    check("t5_all_tc", 32'(tc), 32'hF);
    check("t5_busy", 32'(busy), 32'hF);
    rst = 1'b1;
    step();
    check("t6_tc", 32'(tc), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_count_lo", count[31:0], 32'd0);
    check("t6_count_hi", count[63:32], 32'd0);
    rst = 1'b0;
    repeat (20) step();
    check("t6_busy_after", 32'(busy), 32'd0);
    check("t6_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
